// File: rtl/pong_pkg.sv
// pong_pkg: constants and types shared by the pong game blocks.
//   SCREEN_W / SCREEN_H : visible area in pixels
//   BAR_W / BAR_H       : paddle sprite size (must match the renderer)
//   barra_state_t       : paddle controller FSM state encoding
package pong_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BAR_W    = 64;
  localparam int BAR_H    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_L = 2'd1,
    MOVE_R = 2'd2
  } barra_state_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a stability counter for one
// raw push-button. The output level follows the synchronized input only
// after the two have differed for DEBOUNCE_CYCLES consecutive clocks; any
// bounce back to the current level reloads the counter.
//   clk    : sampling clock
//   reset  : asynchronous, active-high
//   btn    : raw asynchronous button
//   level  : debounced level (press-to-level latency 2 + DEBOUNCE_CYCLES)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt_q;

  // Down-counter: reaching zero while still differing means the input has
  // been stable for the full window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt_q  <= CNT_LOAD;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      if (sync_b == level) begin
        cnt_q <= CNT_LOAD;
      end else if (cnt_q == '0) begin
        level <= sync_b;
        cnt_q <= CNT_LOAD;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/barra_ctrl.sv
// barra_ctrl: per-frame position controller for the player paddle.
// Debounces the two buttons, runs a direction FSM and moves/clamps the
// paddle once per frame on the rising edge of the synchronized vsync, so
// sprite_x is stable when the renderer latches it on the falling edge.
//
// Build option: BARRA_ACCEL_EN -- when defined, speed grows by 1 px/frame
// every ACCEL_FRAMES held frames up to MAX_STEP (those two parameters exist
// only in that build). When undefined, speed is fixed at STEP.
//
// Ports:
//   clk        : pixel clock (only clock)
//   reset      : asynchronous, active-high
//   vsync      : raw vertical sync
//   btn_left   : raw button, active-high
//   btn_right  : raw button, active-high
//   sprite_x   : paddle left edge
//   sprite_y   : paddle top edge (constant BAR_Y)
//   moving     : FSM in MOVE_L or MOVE_R
//   frame_tick : one-cycle pulse coincident with the updated sprite_x
//
// state  | meaning
// IDLE   | no single button held, paddle still
// MOVE_L | left held alone, paddle moving toward x = 0
// MOVE_R | right held alone, paddle moving toward SCREEN_W - BAR_W
module barra_ctrl #(
  parameter int SCREEN_W        = pong_pkg::SCREEN_W,
  parameter int BAR_W           = pong_pkg::BAR_W,
  parameter int BAR_Y           = 440,
  parameter int X_INIT          = 288,
  parameter int STEP            = 4,
`ifdef BARRA_ACCEL_EN
  parameter int MAX_STEP        = 12,
  parameter int ACCEL_FRAMES    = 8,
`endif
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic       moving,
  output logic       frame_tick
);

  import pong_pkg::*;

  localparam logic [9:0]        X_RESET  = 10'(X_INIT);
  localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - BAR_W);
  localparam logic [9:0]        SPD_BASE = 10'(STEP);

  logic               vs_meta;
  logic               vs_sync;
  logic               vs_prev;
  logic               tick;
  logic               lvl_left;
  logic               lvl_right;
  barra_state_t       state_q;
  barra_state_t       state_d;
  logic [9:0]         x_q;
  logic [9:0]         x_d;
  logic [9:0]         step_now;
  logic signed [10:0] x_ext;
  logic signed [10:0] step_ext;
  logic signed [10:0] x_mv;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_left),
    .level (lvl_left)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_right),
    .level (lvl_right)
  );

  // Rising edge of synchronized vsync; registers update on the edge that
  // loads vs_prev, three clocks after the pin rises.
  assign tick = vs_sync & ~vs_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_meta    <= 1'b0;
      vs_sync    <= 1'b0;
      vs_prev    <= 1'b0;
      state_q    <= IDLE;
      x_q        <= X_RESET;
      frame_tick <= 1'b0;
    end else begin
      vs_meta    <= vsync;
      vs_sync    <= vs_meta;
      vs_prev    <= vs_sync;
      state_q    <= state_d;
      x_q        <= x_d;
      frame_tick <= tick;
    end
  end

  // From any state, a single held button selects its direction; both or
  // neither returns to IDLE. Uses the registered debounced levels.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case ({lvl_left, lvl_right})
        2'b10:   state_d = MOVE_L;
        2'b01:   state_d = MOVE_R;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef BARRA_ACCEL_EN
  localparam int HW = $clog2(ACCEL_FRAMES + 1);
  localparam logic [HW-1:0] HELD_LAST = HW'(ACCEL_FRAMES - 1);
  localparam logic [9:0]    SPD_MAX   = 10'(MAX_STEP);

  logic [9:0]    speed_q;
  logic [9:0]    speed_d;
  logic [HW-1:0] held_q;
  logic [HW-1:0] held_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_q <= SPD_BASE;
      held_q  <= '0;
    end else begin
      speed_q <= speed_d;
      held_q  <= held_d;
    end
  end

  // Entering a MOVE state (or leaving to IDLE) restarts at base speed, so
  // the first frame of any movement steps by STEP.
  always_comb begin
    speed_d = speed_q;
    held_d  = held_q;
    if (tick) begin
      if ((state_d == IDLE) || (state_d != state_q)) begin
        speed_d = SPD_BASE;
        held_d  = '0;
      end else if (held_q == HELD_LAST) begin
        held_d  = '0;
        speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 10'd1;
      end else begin
        held_d = held_q + 1'b1;
      end
    end
  end

  // Movement uses the speed that applies after this tick's update.
  assign step_now = speed_d;
`else
  assign step_now = SPD_BASE;
`endif

  // Signed 11-bit arithmetic so a left move past 0 goes negative instead
  // of wrapping, then clamps.
  always_comb begin
    x_d      = x_q;
    x_ext    = signed'({1'b0, x_q});
    step_ext = signed'({1'b0, step_now});
    x_mv     = x_ext;
    if (tick) begin
      case (state_d)
        MOVE_L: begin
          x_mv = x_ext - step_ext;
          if (x_mv < 0) x_mv = '0;
        end
        MOVE_R: begin
          x_mv = x_ext + step_ext;
          if (x_mv > X_MAX) x_mv = X_MAX;
        end
        default: x_mv = x_ext;
      endcase
      x_d = x_mv[9:0];
    end
  end

  assign sprite_x = x_q;
  assign sprite_y = 10'(BAR_Y);
  assign moving   = (state_q != IDLE);

endmodule

// File: doc/barra_ctrl.md
# barra_ctrl

Per-frame position controller for the player paddle. It takes two push-buttons and produces the `sprite_x`/`sprite_y` coordinates consumed by the paddle sprite renderer. It debounces the buttons, runs a direction/speed state machine, and clamps the paddle to the visible area. It updates position once per frame, timed so the coordinates are stable when the renderer samples them on the falling edge of `vsync`.

## Interface
- `SCREEN_W`, 640: visible width in pixels.
- `BAR_W`, 64: paddle width. Must match the renderer's sprite width.
- `BAR_Y`, 440: fixed paddle row, driven on `sprite_y`.
- `X_INIT`, 288: x position after reset.
- `STEP`, 4: base movement in pixels per frame.
- `MAX_STEP`, 12: speed cap in pixels per frame.
- `ACCEL_FRAMES`, 8: number of held frames per +1 speed increment.
- `DEBOUNCE_CYCLES`, 250000: number of stable clocks required to accept a button change.
- `clk`, in, 1: pixel clock. This is the block's only clock.
- `reset`, in, 1: asynchronous, active-high.
- `vsync`, in, 1: raw vertical sync from the video timing generator.
- `btn_left`, in, 1: raw button, active-high, asynchronous.
- `btn_right`, in, 1: raw button, active-high, asynchronous.
- `sprite_x`, out, 10: paddle left edge.
- `sprite_y`, out, 10: paddle top edge. Always equals `BAR_Y`.
- `moving`, out, 1: high while the FSM is in MOVE_L or MOVE_R.
- `frame_tick`, out, 1: one-cycle pulse when the position update is applied.

## Operation
- **Reset values:**
  - `sprite_x` = `X_INIT`, `sprite_y` = `BAR_Y`.
  - `moving` = 0, `frame_tick` = 0.
  - FSM = IDLE, speed = `STEP`, held-frame counter = 0.
  - Synchronizers and debounce outputs = 0.
- **vsync path:**
  - 2-flop synchronizer, then a rising-edge detector.
  - The rising edge of synchronized `vsync` is the frame tick.
  - Updating at the end of the sync pulse keeps `sprite_x` constant across the next falling edge, where the renderer latches it.
- **Buttons:**
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive clocks.
  - Any bounce restarts the count.
- **FSM.** Decisions are evaluated only on the frame tick, using the debounced levels L and R.
  - IDLE: L&!R → MOVE_L. R&!L → MOVE_R. Otherwise stay in IDLE.
  - MOVE_L: L&!R → stay. R&!L → MOVE_R with speed reset to `STEP`. Otherwise → IDLE.
  - MOVE_R: symmetric to MOVE_L.
  - Both buttons pressed, or neither: → IDLE, speed = `STEP`, counter = 0.
- **Movement.** On each frame tick, in the post-transition state:
  - MOVE_L: x = max(x − speed, 0).
  - MOVE_R: x = min(x + speed, `SCREEN_W` − `BAR_W`).
  - Arithmetic is 11-bit signed, so there is no wrap-around. The clamped result is truncated to 10 bits.
  - The paddle's first movement frame (entering a MOVE state) moves by `STEP`.
- **Acceleration:**
  - The held-frame counter increments on every tick spent in the same MOVE state.
  - When the counter reaches `ACCEL_FRAMES`: counter = 0, speed = min(speed + 1, `MAX_STEP`).
- **Boundaries:**
  - At the limit with the button still held: x stays clamped, state stays MOVE, `moving` = 1.
  - Reset asserted mid-frame forces all reset values immediately.

## Timing
- A `vsync` rising edge at the pin produces the update 3 clocks later:
  - cycle 1: first synchronizer flop;
  - cycle 2: second synchronizer flop;
  - cycle 3: edge-detect register, then `sprite_x`, the FSM and `frame_tick` update on the same edge.
- `frame_tick` is high for exactly 1 clock, coincident with the new `sprite_x`.
- Button press to debounced level: 2 + `DEBOUNCE_CYCLES` clocks. Movement begins at the next frame tick.
- A debounced change in the same cycle as the frame tick is not seen until the following tick; the FSM uses the registered level.

## Configuration
- `BARRA_ACCEL_EN` defined: acceleration as described above.
- `BARRA_ACCEL_EN` undefined:
  - speed is fixed at `STEP`;
  - the held-frame counter and speed register are not built;
  - FSM and clamping are unchanged.

## Structure
- Shared package `pong_pkg`:
  - screen constants (`SCREEN_W`, `SCREEN_H`);
  - `BAR_W`, `BAR_H`;
  - FSM state typedef `barra_state_t` {IDLE, MOVE_L, MOVE_R}.
- Sub-module `btn_debounce`: synchronizer plus counter, instantiated once per button, parameter `DEBOUNCE_CYCLES`.

## Test plan
Bench settings: `DEBOUNCE_CYCLES`=4, frame period = 100 clocks.

- **Reset:** reset asserted → `sprite_x`=288, `sprite_y`=440, `moving`=0. No change over 3 frames with no buttons.
- **Right press, acceleration off:** `btn_right` held for 3 frames → x = 292, 296, 300. `moving`=1. `frame_tick` lands 3 clocks after each `vsync` rise.
- **Acceleration on:** `btn_left` held for 10 frames from x=288 → steps 4×8, then 5, 5. Final x = 246.
- **Clamp:** start x=574, hold right → x = 576 and stays at 576. No wrap to a small value.
- **Both buttons:** both held → FSM IDLE, x unchanged, speed back to 4 on the next single press.
- **Bounce and reset:**
  - right toggled every 2 clocks for 20 clocks → no movement;
  - reset pulse mid-move → x = 288 immediately.
